dm_byteen_responder: RTL and testbench

- Responder end of the CPU data-memory port: the CPU drives m_data_addr/m_data_wdata/m_data_byteen/m_inst_addr; this block returns m_data_rdata.
- Word-organised RAM with byte-enable merge writes and a hardware zero-fill sequencer after reset.
- Each committed store is pushed as a trace record (pc, word address, merged word) into a small FIFO, drained over a valid/ready port for logging or checking.
- Sits between the pipelined CPU's M stage and the system/bench top.

---
 rtl/dm_byteen_responder_if.sv | 27 ++
 rtl/dm_byteen_responder.sv | 141 ++++++++++++++
 tb/tb_dm_byteen_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_byteen_responder_if.sv
// rtl/dm_byteen_responder_if.sv - CPU data-memory port and store-trace stream bundle
interface dm_byteen_responder_if;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        busy;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        trace_overflow;

    modport master (
        output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        input  m_data_rdata, busy, trace_valid, trace_pc, trace_addr, trace_data,
               trace_overflow
    );

    modport slave (
        input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        output m_data_rdata, busy, trace_valid, trace_pc, trace_addr, trace_data,
               trace_overflow
    );
endinterface

// File: rtl/dm_byteen_responder.sv
// rtl/dm_byteen_responder.sv - byte-enable data RAM with zero-fill sweep and store trace FIFO
module dm_byteen_responder #(
    parameter int ADDR_W      = 12,
    parameter int TRACE_DEPTH = 8
) (
    input logic                  clk,
    input logic                  reset,
    dm_byteen_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_we;
    logic              running;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] index;
    logic              in_range;
    logic [31:0]       rd_word;
    logic [31:0]       merged;
    logic              store;

    logic [31:0]       fifo_pc   [TRACE_DEPTH];
    logic [31:0]       fifo_addr [TRACE_DEPTH];
    logic [31:0]       fifo_data [TRACE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              pop;
    logic              push;
    logic              overflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_cnt == '1) begin
            state_nxt = ST_RUN;
        end
    end

    always_comb begin
        clr_we  = 1'b0;
        running = 1'b0;
        case (state)
            ST_CLEAR: clr_we  = 1'b1;
            ST_RUN:   running = 1'b1;
            default:  clr_we  = 1'b1;
        endcase
    end

    // Sweep counter wraps to 0 on the last write, so a later reset restarts cleanly from index 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (clr_we) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign index    = bus.m_data_addr[ADDR_W+1:2];
    assign in_range = (bus.m_data_addr[31:ADDR_W+2] == '0);
    assign rd_word  = mem[index];
    assign store    = running && in_range && (bus.m_data_byteen != 4'b0000);

    always_comb begin
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.m_data_byteen[i]) begin
                merged[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= 32'h0000_0000;
        end else if (store) begin
            mem[index] <= merged;
        end
    end

    assign bus.m_data_rdata = (running && in_range) ? rd_word : 32'h0000_0000;
    assign bus.busy         = clr_we;

    assign full = (count == CNT_W'(TRACE_DEPTH));
    assign pop  = bus.trace_valid && bus.trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the new record.
    assign push = store && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= bus.m_inst_addr;
            fifo_addr[wr_ptr] <= bus.m_data_addr & 32'hFFFF_FFFC;
            fifo_data[wr_ptr] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (store && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.trace_valid    = (count != '0);
    assign bus.trace_pc       = bus.trace_valid ? fifo_pc[rd_ptr]   : 32'h0000_0000;
    assign bus.trace_addr     = bus.trace_valid ? fifo_addr[rd_ptr] : 32'h0000_0000;
    assign bus.trace_data     = bus.trace_valid ? fifo_data[rd_ptr] : 32'h0000_0000;
    assign bus.trace_overflow = overflow;
endmodule

// File: tb/tb_dm_byteen_responder.sv
// tb/tb_dm_byteen_responder.sv - self-checking bench for dm_byteen_responder
module tb_dm_byteen_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dm_byteen_responder_if bus ();

    dm_byteen_responder #(.ADDR_W(12), .TRACE_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_m [4096];
    logic [31:0] q_pc [$];
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    logic        ovf_m = 1'b0;
    logic        run_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] pc, input logic rdy);
        bus.m_data_addr   = a;
        bus.m_data_wdata  = d;
        bus.m_data_byteen = be;
        bus.m_inst_addr   = pc;
        bus.trace_ready   = rdy;
    endtask

    task automatic chk_rdata(input string tag);
        logic [31:0] a;
        a = bus.m_data_addr;
        chk(tag, bus.m_data_rdata, (a[31:14] == 18'd0) ? mem_m[a[13:2]] : 32'h0);
    endtask

    task automatic chk_trace(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.trace_valid}, {31'd0, q_pc.size() != 0});
        chk({tag, "_pc"},   bus.trace_pc,   (q_pc.size() != 0) ? q_pc[0]   : 32'h0);
        chk({tag, "_addr"}, bus.trace_addr, (q_pc.size() != 0) ? q_addr[0] : 32'h0);
        chk({tag, "_data"}, bus.trace_data, (q_pc.size() != 0) ? q_data[0] : 32'h0);
        chk({tag, "_ovf"},  {31'd0, bus.trace_overflow}, {31'd0, ovf_m});
    endtask

    // Reference: apply the current inputs to the word array and record queue, then clock once.
    task automatic cycle(input string tag);
        logic [31:0] a, w, lane;
        int          size_before;
        bit          popm;
        a = bus.m_data_addr;
        size_before = q_pc.size();
        popm = (size_before != 0) && bus.trace_ready;
        if (popm) begin
            void'(q_pc.pop_front());
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end
        if (run_m && bus.m_data_byteen != 4'd0 && a[31:14] == 18'd0) begin
            w = mem_m[a[13:2]];
            for (int i = 0; i < 4; i++) begin
                if (bus.m_data_byteen[i]) begin
                    lane = 32'hFF << (8 * i);
                    w = (w & ~lane) | (bus.m_data_wdata & lane);
                end
            end
            mem_m[a[13:2]] = w;
            if (size_before == 8 && !popm) begin
                ovf_m = 1'b1;
            end else begin
                q_pc.push_back(bus.m_inst_addr);
                q_addr.push_back({a[31:2], 2'b00});
                q_data.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        chk_trace(tag);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        run_m = 1'b0;
        ovf_m = 1'b0;
        q_pc.delete();
        q_addr.delete();
        q_data.delete();
        foreach (mem_m[i]) mem_m[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd1);
        chk_trace("rst");
        reset = 1'b1;
    endtask

    task automatic wait_clear(input string tag);
        int n;
        bit bad;
        n = 0;
        bad = 0;
        // A store held during the sweep must be ignored and leave no record.
        set_in(32'h20, 32'hDEAD_BEEF, 4'hF, 32'h1, 1'b1);
        while (bus.busy === 1'b1 && n < 5000) begin
            if (bus.trace_valid !== 1'b0 || bus.m_data_rdata !== 32'h0) bad = 1;
            n++;
            @(posedge clk);
            #1;
        end
        set_in(0, 0, 0, 0, 0);
        chk({tag, "_busy_cycles"}, 32'(n), 32'd4096);
        chk({tag, "_quiet_in_clear"}, {31'd0, bad}, 32'd0);
        run_m = 1'b1;
        set_in(32'h20, 0, 0, 0, 0);
        #1;
        chk({tag, "_rd20"}, bus.m_data_rdata, 32'h0);
        set_in(32'h3FFC, 0, 0, 0, 0);
        #1;
        chk({tag, "_rd3ffc"}, bus.m_data_rdata, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(0, 0, 0, 0, 0);
        apply_reset();
        wait_clear("clr1");

        set_in(32'h10, 32'h1234_5678, 4'hF, 32'h3000, 1'b0);
        #1;
        chk("sw_no_bypass", bus.m_data_rdata, 32'h0);
        cycle("sw");
        chk("sw_pc", bus.trace_pc, 32'h3000);
        chk("sw_addr", bus.trace_addr, 32'h10);
        chk("sw_data", bus.trace_data, 32'h1234_5678);
        set_in(32'h11, 32'h0000_AB00, 4'b0010, 32'h3004, 1'b0);
        #1;
        chk("sw_rd", bus.m_data_rdata, 32'h1234_5678);
        cycle("sb");
        set_in(32'h10, 0, 0, 0, 1'b1);
        #1;
        chk("sb_rd", bus.m_data_rdata, 32'h1234_AB78);
        cycle("pop1");
        chk("sb_addr", bus.trace_addr, 32'h10);
        chk("sb_data", bus.trace_data, 32'h1234_AB78);
        cycle("pop2");

        set_in(32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 32'h5000, 1'b0);
        #1;
        chk("oor_rd", bus.m_data_rdata, 32'h0);
        cycle("oor");
        chk("oor_novalid", {31'd0, bus.trace_valid}, 32'd0);
        set_in(32'h0, 0, 0, 0, 0);
        #1;
        chk_rdata("oor_alias0");

        for (int i = 0; i < 9; i++) begin
            set_in(32'h100 + 32'(4 * i), $urandom, 4'hF, 32'h4000 + 32'(4 * i), 1'b0);
            cycle("fill9");
        end
        chk("fill9_ovf", {31'd0, bus.trace_overflow}, 32'd1);
        set_in(0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 9; i++) cycle("drain9");
        chk("drain9_empty", {31'd0, bus.trace_valid}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = {24'd0, 4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom)} + 32'h200;
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(14, 31));
            set_in(a, $urandom, 4'($urandom), $urandom, 1'($urandom_range(0, 2) != 0));
            #1;
            chk_rdata("rnd_rd");
            cycle("rnd");
        end

        apply_reset();
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_clear("clr2");

        for (int i = 0; i < 8; i++) begin
            set_in(32'h40 + 32'(4 * i), $urandom, 4'hF, 32'h6000 + 32'(4 * i), 1'b0);
            cycle("full8");
        end
        chk("full8_ovf", {31'd0, bus.trace_overflow}, 32'd0);
        set_in(32'h80, 32'hCAFE_F00D, 4'hF, 32'h7000, 1'b1);
        cycle("full_pushpop");
        chk("pushpop_ovf", {31'd0, bus.trace_overflow}, 32'd0);
        set_in(32'h84, 32'h0BAD_CAFE, 4'hF, 32'h7004, 1'b0);
        cycle("still_full");
        chk("still_full_ovf", {31'd0, bus.trace_overflow}, 32'd1);
        set_in(0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 9; i++) cycle("drain8");
        chk("drain8_empty", {31'd0, bus.trace_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
